// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
//   MULT/MULTU run as shift-add, DIV/DIVU as restoring division, one bit per
//   cycle on operand magnitudes. Signs are applied in a final FIX cycle.
//   MTHI/MTLO write HI/LO directly from IDLE.
//
// Handshake: start is sampled only in IDLE. busy is high from the edge after
//   an accepted mult/div until the edge that writes HI/LO. That same edge
//   raises done for one cycle, and a new start is accepted in that cycle.
//   start while busy is dropped. flush returns to IDLE at once and wins
//   over start.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start, funct     issue request and R-type funct code
//   op1, op2         rs / rt operand values
//   flush            abort any in-flight op; HI/LO keep their values
//   busy, done       op in flight / one-cycle HI/LO-updated pulse
//   hi, lo           architectural HI/LO registers
//   dbg_state_o      current FSM state (IDLE=0, RUN=1, FIX=2)
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    // Multiply: {partial product high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               is_signed_q, is_signed_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic               divzero_q, divzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand magnitudes at issue. The most-negative value maps onto itself,
    // which is its correct magnitude when read as unsigned.
    logic               op_signed;
    logic [WIDTH-1:0]   mag1, mag2;

    assign op_signed = ~funct[0];
    assign mag1      = (op_signed && op1[WIDTH-1]) ? ('0 - op1) : op1;
    assign mag2      = (op_signed && op2[WIDTH-1]) ? ('0 - op2) : op2;

    // One shift-add multiply step.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step. The shifted remainder is WIDTH+1 bits; when
    // its top bit is set it is certainly >= divisor, so no borrow and the
    // difference fits back into WIDTH bits.
    logic [WIDTH:0]     div_part;
    logic               div_borrow;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign div_part   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_borrow = ~div_part[WIDTH] & (div_part[WIDTH-1:0] < opb_q);
    assign div_diff   = div_part[WIDTH-1:0] - opb_q;
    assign div_next   = {(div_borrow ? div_part[WIDTH-1:0] : div_diff),
                         acc_q[WIDTH-2:0], ~div_borrow};

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = (is_signed_q && (sign1_q ^ sign2_q)) ? ('0 - acc_q) : acc_q;
    // Divide by zero must read back as all-ones regardless of the sign rule.
    assign quo_fix  = divzero_q ? '1 :
                      ((is_signed_q && (sign1_q ^ sign2_q)) ? ('0 - acc_q[WIDTH-1:0])
                                                            : acc_q[WIDTH-1:0]);
    assign rem_fix  = (is_signed_q && sign1_q) ? ('0 - acc_q[2*WIDTH-1:WIDTH])
                                               : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        sign1_d     = sign1_q;
        sign2_d     = sign2_q;
        divzero_d   = divzero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (funct)
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                is_div_d    = funct[1];
                                is_signed_d = op_signed;
                                sign1_d     = op_signed & op1[WIDTH-1];
                                sign2_d     = op_signed & op2[WIDTH-1];
                                divzero_d   = (op2 == '0);
                                opb_d       = funct[1] ? mag2 : mag1;
                                acc_d       = {{WIDTH{1'b0}}, (funct[1] ? mag1 : mag2)};
                                count_d     = '0;
                                state_d     = S_RUN;
                            end
                            F_MTHI:  hi_d = op1;
                            F_MTLO:  lo_d = op1;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc_d   = is_div_q ? div_next : mul_next;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            sign1_q     <= 1'b0;
            sign2_q     <= 1'b0;
            divzero_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            sign1_q     <= sign1_d;
            sign2_q     <= sign2_d;
            divzero_q   <= divzero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = state_q;

endmodule
